alu_decoder: RTL and testbench

- Decodes the main-decoder ALU class bit (ALUD) and the instruction funct field (F) into a 2-bit ALU operation select (ALUOp).
- Sits in the control unit between the main decoder and the ALU.
- Provides a combinational result and an optionally registered result with valid/stall qualification.
- Optional per-operation usage counters are available for debug.

---
 rtl/alu_decoder_pkg.sv | 17 +
 rtl/alu_decoder_stats.sv | 33 +++
 rtl/alu_decoder.sv | 72 +++++++
 tb/tb_alu_decoder.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/alu_decoder_pkg.sv
// Shared ALU op encoding and decode function for the control unit, the ALU and the bench.
package alu_decoder_pkg;

  typedef logic [1:0] alu_op_t;

  localparam alu_op_t ALUOP_ADD = 2'b00;
  localparam alu_op_t ALUOP_XOR = 2'b01;
  localparam alu_op_t ALUOP_AND = 2'b10;
  localparam alu_op_t ALUOP_SRA = 2'b11;

  // The select is tested first so an unknown funct field under ALUD=0 still yields ADD.
  function automatic alu_op_t alu_decode(input logic alud, input logic [2:0] f);
    if (alud == 1'b0) return ALUOP_ADD;
    return alu_op_t'(f[1:0]);
  endfunction

endpackage

// File: rtl/alu_decoder_stats.sv
// Four saturating per-op usage counters with synchronous clear (clear beats increment).
module alu_decoder_stats
  import alu_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  alu_op_t          op,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_xor,
  output logic [CNT_W-1:0] cnt_and,
  output logic [CNT_W-1:0] cnt_sra
);

  logic [3:0][CNT_W-1:0] cnt;

  for (genvar i = 0; i < 4; i++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                      cnt[i] <= '0;
      else if (clr)                                    cnt[i] <= '0;
      else if (inc && op == alu_op_t'(i) && ~&cnt[i])  cnt[i] <= cnt[i] + 1'b1;
    end
  end

  assign cnt_add = cnt[ALUOP_ADD];
  assign cnt_xor = cnt[ALUOP_XOR];
  assign cnt_and = cnt[ALUOP_AND];
  assign cnt_sra = cnt[ALUOP_SRA];

endmodule

// File: rtl/alu_decoder.sv
// ALU decoder: ALUD/F -> 2-bit ALUOp, optionally registered with valid/stall.
// Optional debug counters are built when ALU_DECODER_STATS_EN is defined.
module alu_decoder
  import alu_decoder_pkg::*;
#(
  parameter int REG_OUT = 1
`ifdef ALU_DECODER_STATS_EN
  ,
  parameter int CNT_W   = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             ALUD,
  input  logic [2:0]       F,
  output logic [1:0]       alu_op_comb,
  output logic [1:0]       ALUOp,
  output logic             out_valid
`ifdef ALU_DECODER_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] cnt_add,
  output logic [CNT_W-1:0] cnt_xor,
  output logic [CNT_W-1:0] cnt_and,
  output logic [CNT_W-1:0] cnt_sra
`endif
);

  logic accept;

  assign alu_op_comb = alu_decode(ALUD, F);
  assign accept      = in_valid & ~stall;

  if (REG_OUT != 0) begin : g_reg
    alu_op_t op_q;
    logic    vld_q;

    // An unstalled edge with no valid input drops out_valid but keeps the last op visible.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        op_q  <= ALUOP_ADD;
        vld_q <= 1'b0;
      end else if (!stall) begin
        vld_q <= in_valid;
        if (accept) op_q <= alu_op_comb;
      end
    end

    assign ALUOp     = op_q;
    assign out_valid = vld_q;
  end else begin : g_comb
    assign ALUOp     = alu_op_comb;
    assign out_valid = accept;
  end

`ifdef ALU_DECODER_STATS_EN
  alu_decoder_stats #(.CNT_W(CNT_W)) u_stats (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (stats_clr),
    .inc     (accept),
    .op      (alu_op_comb),
    .cnt_add (cnt_add),
    .cnt_xor (cnt_xor),
    .cnt_and (cnt_and),
    .cnt_sra (cnt_sra)
  );
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: registered and combinational builds side by side,
// directed sweeps plus random stimulus against a behavioural model (stats when ALU_DECODER_STATS_EN).
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, stall, ALUD;
  logic [2:0] F;
  logic [1:0] op_comb_r, op_r, op_comb_c, op_c;
  logic       vld_r, vld_c;
  int         n_tests = 0;
  int         n_fail  = 0;

  // reference state for the registered build
  int         e_op, e_vld;

`ifdef ALU_DECODER_STATS_EN
  localparam int CW = 2;
  logic          stats_clr;
  logic [CW-1:0] c_add, c_xor, c_and, c_sra;
  logic [CW-1:0] x_add, x_xor, x_and, x_sra;
  int            e_cnt [4];
`endif

  always #5 clk = ~clk;

  alu_decoder #(
    .REG_OUT(1)
`ifdef ALU_DECODER_STATS_EN
    , .CNT_W(CW)
`endif
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .ALUD(ALUD), .F(F),
    .alu_op_comb(op_comb_r), .ALUOp(op_r), .out_valid(vld_r)
`ifdef ALU_DECODER_STATS_EN
    , .stats_clr(stats_clr), .cnt_add(c_add), .cnt_xor(c_xor), .cnt_and(c_and), .cnt_sra(c_sra)
`endif
  );

  alu_decoder #(
    .REG_OUT(0)
`ifdef ALU_DECODER_STATS_EN
    , .CNT_W(CW)
`endif
  ) u_dut_comb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .ALUD(ALUD), .F(F),
    .alu_op_comb(op_comb_c), .ALUOp(op_c), .out_valid(vld_c)
`ifdef ALU_DECODER_STATS_EN
    , .stats_clr(stats_clr), .cnt_add(x_add), .cnt_xor(x_xor), .cnt_and(x_and), .cnt_sra(x_sra)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADD for ALUD=0 regardless of F; otherwise the low two funct bits pick the op
  function automatic int ref_op(input logic alud, input logic [2:0] f);
    if (alud !== 1'b1) return 0;
    return int'(f) % 4;
  endfunction

  task automatic model_reset();
    e_op  = 0;
    e_vld = 0;
`ifdef ALU_DECODER_STATS_EN
    foreach (e_cnt[i]) e_cnt[i] = 0;
`endif
  endtask

  task automatic drive(input logic v, input logic s, input logic a, input logic [2:0] f,
                       input logic clr);
    in_valid = v; stall = s; ALUD = a; F = f;
`ifdef ALU_DECODER_STATS_EN
    stats_clr = clr;
`else
    if (clr) $display("[TB] stats clear ignored in this build");
`endif
  endtask

  // Inputs are applied 1 time unit after a rising edge; comb outputs are checked before the
  // next edge and registered outputs 1 unit after it.
  task automatic cycle(input string tag);
    int op;
    op = ref_op(ALUD, F);
    #1;
    chk({tag, ":comb"}, 32'(op_comb_r), 32'(op));
    chk({tag, ":c_op"}, 32'(op_c), 32'(op));
    chk({tag, ":c_vld"}, 32'(vld_c), 32'(in_valid && !stall));
    if (!stall) begin
      e_vld = int'(in_valid);
      if (in_valid) e_op = op;
    end
`ifdef ALU_DECODER_STATS_EN
    if (stats_clr) foreach (e_cnt[i]) e_cnt[i] = 0;
    else if (in_valid && !stall && e_cnt[op] < (1 << CW) - 1) e_cnt[op]++;
`endif
    @(posedge clk);
    #1;
    chk({tag, ":op"}, 32'(op_r), 32'(e_op));
    chk({tag, ":vld"}, 32'(vld_r), 32'(e_vld));
`ifdef ALU_DECODER_STATS_EN
    chk({tag, ":cadd"}, 32'(c_add), 32'(e_cnt[0]));
    chk({tag, ":cxor"}, 32'(c_xor), 32'(e_cnt[1]));
    chk({tag, ":cand"}, 32'(c_and), 32'(e_cnt[2]));
    chk({tag, ":csra"}, 32'(c_sra), 32'(e_cnt[3]));
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    model_reset();
    #12;
    chk("rst_op", 32'(op_r), 32'(0));
    chk("rst_vld", 32'(vld_r), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("idle");

    // ALUD=0 sweep
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 1'b0, 1'b0, 3'(f), 1'b0);
      cycle("alud0");
    end
    // ALUD=1 sweep
    for (int f = 0; f < 8; f++) begin
      drive(1'b1, 1'b0, 1'b1, 3'(f), 1'b0);
      cycle("alud1");
    end

    // stall holds SRA, then an unstalled idle edge drops valid and keeps the op
    drive(1'b1, 1'b0, 1'b1, 3'b011, 1'b0); cycle("sra");
    drive(1'b1, 1'b1, 1'b1, 3'b001, 1'b0); cycle("stall");
    chk("stall_op", 32'(op_r), 32'(3));
    chk("stall_vld", 32'(vld_r), 32'(1));
    drive(1'b0, 1'b0, 1'b1, 3'b001, 1'b0); cycle("unstall");
    chk("idle_op", 32'(op_r), 32'(3));
    chk("idle_vld", 32'(vld_r), 32'(0));

    // combinational build directed check
    drive(1'b1, 1'b0, 1'b1, 3'b110, 1'b0); #1;
    chk("comb_and_op", 32'(op_c), 32'(2));
    chk("comb_and_vld", 32'(vld_c), 32'(1));
    stall = 1'b1; #1;
    chk("comb_stall_vld", 32'(vld_c), 32'(0));
    @(posedge clk); #1;
    stall = 1'b0;

    // unknown funct under ALUD=0 must still decode to ADD
    drive(1'b1, 1'b0, 1'b0, 3'bxxx, 1'b0); #1;
    chk("x_free", 32'(op_comb_r), 32'(0));
    @(posedge clk); #1;
    e_vld = 1; e_op = 0;

    // reset asserted mid-cycle clears outputs immediately; stays clear until first accept
    drive(1'b1, 1'b0, 1'b1, 3'b111, 1'b0); cycle("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vld", 32'(vld_r), 32'(0));
    chk("midrst_op", 32'(op_r), 32'(0));
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 3'b111, 1'b0);
    @(posedge clk); #1;
    cycle("post_rst_idle");
    drive(1'b1, 1'b0, 1'b1, 3'b101, 1'b0); cycle("post_rst_acc");

`ifdef ALU_DECODER_STATS_EN
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1); cycle("clr0");
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b1, 3'b001, 1'b0); cycle("xor4");
    end
    chk("xor_sat", 32'(c_xor), 32'(3));
    drive(1'b1, 1'b0, 1'b0, 3'b000, 1'b1); cycle("clr_add");
    chk("clr_add_cnt", 32'(c_add), 32'(0));
    chk("clr_xor_cnt", 32'(c_xor), 32'(0));
`endif

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0), 1'($urandom),
            3'($urandom), 1'($urandom_range(0, 15) == 0));
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
